ps2_host_tx: RTL
================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter CLKFREQ, default 28000000: system clock frequency in Hz; all timing counts derive from it.
REQ-002 Parameter INHIBIT_US, default 100: minimum time in microseconds the PS/2 clock is held low before the request-to-send.
REQ-003 Parameter FILTER_LEN, default 8: number of consecutive equal synchronised samples needed to accept a new PS/2 clock level.
REQ-004 clk  in  1  system clock; single clock domain.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 data  in  8  byte to transmit to the keyboard.
REQ-007 dataload  in  1  one-cycle start strobe; data is sampled on the same edge.
REQ-008 ps2clk_in  in  1  raw PS/2 clock line level (asynchronous).
REQ-009 ps2data_in  in  1  raw PS/2 data line level (asynchronous).
REQ-010 ps2clk_oe  out  1  1 = drive PS/2 clock low; 0 = release (open drain).
REQ-011 ps2data_oe  out  1  1 = drive PS/2 data low; 0 = release.
REQ-012 ps2busy  out  1  transaction in progress.
REQ-013 ps2error  out  1  sticky error flag for the last transaction.

Function
REQ-014 ps2clk_in and ps2data_in SHALL pass through a 2-flop synchroniser; the clock SHALL be filtered per FILTER_LEN; a falling edge is a filtered 1->0 transition.
REQ-015 FSM states SHALL be IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE.
REQ-016 IDLE: both oe low, ps2busy=0; dataload=1 latches data, computes odd parity, clears ps2error and enters INHIBIT; ps2busy=1 from the next cycle.
REQ-017 INHIBIT: ps2clk_oe=1 for CLKFREQ/1000000*INHIBIT_US cycles (2800 at default), then go to REQ.
REQ-018 REQ: ps2data_oe=1 and ps2clk_oe=0 in the same cycle (start bit 0), then go to SEND with bit index 0.
REQ-019 SEND: on each device clock falling edge, present the next bit: data[0]..data[7] LSB first, then parity, then stop; bit value 0 sets ps2data_oe=1 and bit value 1 sets ps2data_oe=0; stop bit is always released.
REQ-020 After the falling edge that follows the stop bit, sample synchronised ps2data_in: a 0 goes to WAIT_IDLE with no error; a 1 sets ps2error=1 and goes to WAIT_IDLE.
REQ-021 WAIT_IDLE: wait until both filtered lines are high, then go to IDLE; ps2busy deasserts on the IDLE entry cycle.
REQ-022 dataload while ps2busy=1 SHALL be ignored; the latched byte is unaffected.
REQ-023 Simultaneous dataload and WAIT_IDLE->IDLE transition: the strobe is ignored.
REQ-024 ps2error SHALL hold its value until the next accepted dataload or reset.
REQ-025 Counters SHALL be at least 24 bits, saturate only by FSM exit, and never wrap within a transaction.

Reset
REQ-026 rst_n=0 SHALL asynchronously force state IDLE, ps2clk_oe=0, ps2data_oe=0, ps2busy=0, ps2error=0, counters and bit index 0, and synchroniser/filter state 1 (idle bus).
REQ-027 Reset asserted mid-transaction SHALL release both lines immediately; no partial frame resumes after release.
REQ-028 Reset release SHALL be synchronised internally; the first accepted dataload is possible no earlier than cycle 2 after deassertion.

Configuration
REQ-029 Macro PS2_HOST_TX_TIMEOUT_EN: when defined, a watchdog SHALL start on leaving INHIBIT; if IDLE is not reached within CLKFREQ/1000*15 cycles (15 ms), it SHALL release both lines, set ps2error=1 and go to IDLE.
REQ-030 Without PS2_HOST_TX_TIMEOUT_EN, no watchdog logic SHALL exist, and a silent device SHALL leave ps2busy=1 until a clock edge or reset occurs.

Verification
REQ-031 data=0xED, device model clocks at 12.5 kHz and acks -> line bits 0,1,0,1,1,0,1,1,1,1(parity),1(stop); ps2error=0; ps2busy=0 after lines idle.
REQ-032 data=0xF4, device model omits ack (data high) -> parity bit 0 transmitted; ps2error=1 after the ack edge; the flag persists until the next dataload.
REQ-033 dataload with 0x55, then dataload with 0xAA during SEND -> only 0x55 is transmitted; 0xAA is never seen on the line.
REQ-034 Measure INHIBIT at default parameters -> ps2clk_oe high for exactly 2800 cycles before ps2data_oe rises.
REQ-035 rst_n pulsed low during bit 4 of 0x12 -> both oe=0 within the reset; ps2busy=0, ps2error=0; a subsequent send of 0x12 completes correctly.
REQ-036 With PS2_HOST_TX_TIMEOUT_EN, device never clocks -> after 420000 cycles, lines are released, ps2error=1, ps2busy=0.

Source files
------------

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device byte transmitter (optional watchdog: PS2_HOST_TX_TIMEOUT_EN)
`timescale 1ns/1ps
module ps2_host_tx #(
  parameter int CLKFREQ    = 28000000,
  parameter int INHIBIT_US = 100,
  parameter int FILTER_LEN = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       dataload,
  input  logic       ps2clk_in,
  input  logic       ps2data_in,
  output logic       ps2clk_oe,
  output logic       ps2data_oe,
  output logic       ps2busy,
  output logic       ps2error
);

  localparam logic [23:0] INHIBIT_CYC = 24'(CLKFREQ / 1000000 * INHIBIT_US);
  localparam int          FW          = $clog2(FILTER_LEN + 1);
`ifdef PS2_HOST_TX_TIMEOUT_EN
  localparam logic [23:0] TIMEOUT_CYC = 24'(CLKFREQ / 1000 * 15);
`endif

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE} state_t;

  state_t        state, state_n;
  logic [23:0]   cnt, cnt_n;
  logic [3:0]    bit_idx, bit_n;
  logic [9:0]    frame, frame_n;     // {stop, parity, data[7:0]}
  logic          tx_oe, tx_n;        // level currently presented on the data line
  logic          err, err_n;
  logic [1:0]    rst_q;
  logic          rst_ok;
  logic [1:0]    s1, s2, filt;       // bit 0 = clock line, bit 1 = data line
  logic [FW-1:0] fcnt [2];
  logic          clk_fall;
`ifdef PS2_HOST_TX_TIMEOUT_EN
  logic [23:0]   wd, wd_n;
`endif

  // Reset release is re-timed so a strobe right after deassertion cannot start a frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_q <= 2'b00;
    else        rst_q <= {rst_q[0], 1'b1};
  end
  assign rst_ok = rst_q[1];

  // Two-flop synchronisers and glitch filters for both bus lines; idle bus reads high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= 2'b11;
      s2      <= 2'b11;
      filt    <= 2'b11;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
    end else begin
      s1 <= {ps2data_in, ps2clk_in};
      s2 <= s1;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
          filt[i] <= s2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FW'(1);
        end
      end
    end
  end

  // Device clock falling edge: the filtered clock is about to flip from 1 to 0
  assign clk_fall = filt[0] & ~s2[0] & (fcnt[0] == FW'(FILTER_LEN - 1));

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      frame   <= '0;
      tx_oe   <= 1'b0;
      err     <= 1'b0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
      wd      <= '0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      frame   <= frame_n;
      tx_oe   <= tx_n;
      err     <= err_n;
`ifdef PS2_HOST_TX_TIMEOUT_EN
      wd      <= wd_n;
`endif
    end
  end

  // Next-state logic and open-drain line controls
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_n      = bit_idx;
    frame_n    = frame;
    tx_n       = tx_oe;
    err_n      = err;
    ps2clk_oe  = 1'b0;
    ps2data_oe = 1'b0;
    ps2busy    = (state != IDLE);
    ps2error   = err;
    case (state)
      IDLE: begin
        cnt_n = '0;
        bit_n = '0;
        tx_n  = 1'b0;
        if (dataload && rst_ok) begin
          frame_n = {1'b1, ~^data, data};
          err_n   = 1'b0;
          state_n = INHIBIT;
        end
      end
      INHIBIT: begin
        ps2clk_oe = 1'b1;
        if (cnt == INHIBIT_CYC - 24'd1) begin
          cnt_n   = '0;
          state_n = REQ;
        end else begin
          cnt_n = cnt + 24'd1;
        end
      end
      REQ: begin
        ps2data_oe = 1'b1;                 // start bit while the clock is released
        tx_n       = 1'b1;
        bit_n      = '0;
        state_n    = SEND;
      end
      SEND: begin
        ps2data_oe = tx_oe;
        if (clk_fall) begin
          tx_n = ~frame[bit_idx];
          if (bit_idx == 4'd9) state_n = ACK;
          else                 bit_n   = bit_idx + 4'd1;
        end
      end
      ACK: begin
        ps2data_oe = tx_oe;
        if (clk_fall) begin
          err_n   = s2[1];                 // device must hold data low for the ack
          state_n = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (filt == 2'b11) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
`ifdef PS2_HOST_TX_TIMEOUT_EN
    // Watchdog runs from the request-to-send until the bus returns to idle
    if (state == IDLE || state == INHIBIT) begin
      wd_n = '0;
    end else if (wd == TIMEOUT_CYC - 24'd1) begin
      wd_n    = '0;
      err_n   = 1'b1;
      state_n = IDLE;
    end else begin
      wd_n = wd + 24'd1;
    end
`endif
  end

endmodule
